// File: rtl/int_sequencer_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer.
// The flag word stacked on entry carries the flags in its low bits and the saved enable above them.
package int_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_PC,
    S_PUSH_FL,
    S_VECTOR,
    S_POP_FL,
    S_POP_PC,
    S_RESTORE
  } state_t;

  localparam int FL_W_DEF  = 8;
  localparam int IE_BIT    = FL_W_DEF;
  localparam int NO_VECTOR = 0;

  // Position of the saved enable inside the stacked flag word for a given flag width.
  function automatic int ie_bit(input int fl_w);
    return fl_w;
  endfunction

endpackage

// File: rtl/int_sequencer.sv
// CPU-side interrupt sequencer: stacks PC/flags/enable on entry, loads the vector and acks,
// and on RETI pops and restores them before signalling end-of-interrupt.
module int_sequencer
  import int_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int FL_W = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            irq_req,
  input  logic [PC_W-1:0] irq_vec,
  output logic            irq_ack,
  output logic            eoi,
  input  logic            instr_done,
  input  logic            reti,
  input  logic            ie_set,
  input  logic            ie_clr,
  input  logic [PC_W-1:0] pc_in,
  input  logic [FL_W-1:0] flags_in,
  output logic            push_valid,
  output logic [PC_W-1:0] push_data,
  input  logic            push_ready,
  output logic            pop_valid,
  input  logic [PC_W-1:0] pop_data,
  input  logic            pop_ready,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_value,
  output logic            flags_load,
  output logic [FL_W-1:0] flags_out,
  output logic            cpu_stall,
  output logic            ie,
  output logic            in_service
);

  localparam int IE_POS = ie_bit(FL_W);

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_sav_reg, pc_sav_next;
  logic [FL_W-1:0]   fl_sav_reg, fl_sav_next;
  logic              ie_sav_reg, ie_sav_next;
  logic [PC_W-1:0]   vec_reg, vec_next;
  logic              ie_reg, ie_next;
  logic              isr_reg, isr_next;
  logic              push_valid_reg, push_valid_next;
  logic [PC_W-1:0]   push_data_reg, push_data_next;
  logic              pop_valid_reg, pop_valid_next;
  logic              pc_load_reg, pc_load_next;
  logic [PC_W-1:0]   pc_value_reg, pc_value_next;
  logic              flags_load_reg, flags_load_next;
  logic [FL_W-1:0]   flags_out_reg, flags_out_next;
  logic              irq_ack_reg, irq_ack_next;
  logic              eoi_reg, eoi_next;
  logic              stall_reg, stall_next;
  logic [PC_W-1:0]   fl_word;

  // Outputs are registered from the next state, so each one lines up with the state it describes.
  always_comb begin
    state_next      = state_reg;
    pc_sav_next     = pc_sav_reg;
    fl_sav_next     = fl_sav_reg;
    ie_sav_next     = ie_sav_reg;
    vec_next        = vec_reg;
    ie_next         = ie_reg;
    isr_next        = isr_reg;
    push_data_next  = push_data_reg;
    pc_value_next   = pc_value_reg;
    flags_out_next  = flags_out_reg;
    pc_load_next    = 1'b0;
    flags_load_next = 1'b0;
    irq_ack_next    = 1'b0;
    eoi_next        = 1'b0;
    fl_word         = '0;
    fl_word[FL_W-1:0] = fl_sav_reg;
    fl_word[IE_POS]   = ie_sav_reg;

    case (state_reg)
      S_IDLE: begin
        if (ie_clr)      ie_next = 1'b0;
        else if (ie_set) ie_next = 1'b1;
        // RETI has priority; a still-pending request is picked up at a later boundary.
        if (instr_done && reti && isr_reg) begin
          state_next = S_POP_FL;
        end else if (instr_done && irq_req && ie_reg && !isr_reg &&
                     irq_vec != PC_W'(NO_VECTOR)) begin
          state_next     = S_PUSH_PC;
          pc_sav_next    = pc_in;
          fl_sav_next    = flags_in;
          ie_sav_next    = ie_reg;
          vec_next       = irq_vec;
          push_data_next = pc_in;
        end
      end
      S_PUSH_PC: begin
        if (push_ready) begin
          state_next     = S_PUSH_FL;
          push_data_next = fl_word;
        end
      end
      S_PUSH_FL: begin
        if (push_ready) begin
          state_next    = S_VECTOR;
          pc_load_next  = 1'b1;
          pc_value_next = vec_reg;
          irq_ack_next  = 1'b1;
        end
      end
      S_VECTOR: begin
        state_next = S_IDLE;
        ie_next    = 1'b0;
        isr_next   = 1'b1;
      end
      S_POP_FL: begin
        if (pop_ready) begin
          state_next  = S_POP_PC;
          fl_sav_next = pop_data[FL_W-1:0];
          ie_sav_next = pop_data[IE_POS];
        end
      end
      S_POP_PC: begin
        if (pop_ready) begin
          state_next      = S_RESTORE;
          pc_value_next   = pop_data;
          pc_load_next    = 1'b1;
          flags_load_next = 1'b1;
          flags_out_next  = fl_sav_reg;
          eoi_next        = 1'b1;
        end
      end
      S_RESTORE: begin
        state_next = S_IDLE;
        ie_next    = ie_sav_reg;
        isr_next   = 1'b0;
      end
      default: state_next = S_IDLE;
    endcase

    push_valid_next = (state_next == S_PUSH_PC) || (state_next == S_PUSH_FL);
    pop_valid_next  = (state_next == S_POP_FL)  || (state_next == S_POP_PC);
    stall_next      = (state_next != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg      <= S_IDLE;
      pc_sav_reg     <= '0;
      fl_sav_reg     <= '0;
      ie_sav_reg     <= 1'b0;
      vec_reg        <= '0;
      ie_reg         <= 1'b0;
      isr_reg        <= 1'b0;
      push_valid_reg <= 1'b0;
      push_data_reg  <= '0;
      pop_valid_reg  <= 1'b0;
      pc_load_reg    <= 1'b0;
      pc_value_reg   <= '0;
      flags_load_reg <= 1'b0;
      flags_out_reg  <= '0;
      irq_ack_reg    <= 1'b0;
      eoi_reg        <= 1'b0;
      stall_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_sav_reg     <= pc_sav_next;
      fl_sav_reg     <= fl_sav_next;
      ie_sav_reg     <= ie_sav_next;
      vec_reg        <= vec_next;
      ie_reg         <= ie_next;
      isr_reg        <= isr_next;
      push_valid_reg <= push_valid_next;
      push_data_reg  <= push_data_next;
      pop_valid_reg  <= pop_valid_next;
      pc_load_reg    <= pc_load_next;
      pc_value_reg   <= pc_value_next;
      flags_load_reg <= flags_load_next;
      flags_out_reg  <= flags_out_next;
      irq_ack_reg    <= irq_ack_next;
      eoi_reg        <= eoi_next;
      stall_reg      <= stall_next;
    end
  end

  assign irq_ack    = irq_ack_reg;
  assign eoi        = eoi_reg;
  assign push_valid = push_valid_reg;
  assign push_data  = push_data_reg;
  assign pop_valid  = pop_valid_reg;
  assign pc_load    = pc_load_reg;
  assign pc_value   = pc_value_reg;
  assign flags_load = flags_load_reg;
  assign flags_out  = flags_out_reg;
  assign cpu_stall  = stall_reg;
  assign ie         = ie_reg;
  assign in_service = isr_reg;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: a queue acts as the stack, and expected
// timing and data come from the interrupt entry/return rules applied directly.
module tb_int_sequencer;

  logic        CLK, RST;
  logic        irq_req, irq_ack, eoi, instr_done, reti, ie_set, ie_clr;
  logic [15:0] irq_vec, pc_in, push_data, pop_data, pc_value;
  logic [7:0]  flags_in, flags_out;
  logic        push_valid, push_ready, pop_valid, pop_ready;
  logic        pc_load, flags_load, cpu_stall, ie, in_service;

  int_sequencer #(.PC_W(16), .FL_W(8)) dut (
    .CLK(CLK), .RST(RST), .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .eoi(eoi), .instr_done(instr_done), .reti(reti), .ie_set(ie_set), .ie_clr(ie_clr),
    .pc_in(pc_in), .flags_in(flags_in), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .pop_valid(pop_valid), .pop_data(pop_data),
    .pop_ready(pop_ready), .pc_load(pc_load), .pc_value(pc_value),
    .flags_load(flags_load), .flags_out(flags_out), .cpu_stall(cpu_stall),
    .ie(ie), .in_service(in_service)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] stk[$];
  logic [15:0] push_log[$];
  int          push_hold, pop_hold;
  int          cyc, ack_cyc, eoi_cyc, ack_cnt, eoi_cnt, viol;
  logic [15:0] ack_pc, eoi_pc;
  logic [7:0]  eoi_fl;
  logic        ack_pload, eoi_fload;
  int          n_checks, n_fail;
  logic        m_ie, m_isr;

  task automatic clr_obs();
    cyc = 0; ack_cyc = -1; eoi_cyc = -1; ack_cnt = 0; eoi_cnt = 0; viol = 0;
    push_log.delete();
  endtask

  // One clock: model the stack, record pulses, and drive ready for the next edge.
  task automatic step();
    logic        hs_push, hs_pop, prev_wait;
    logic [15:0] pd;
    hs_push   = push_valid && push_ready;
    hs_pop    = pop_valid && pop_ready;
    prev_wait = push_valid && !push_ready;
    pd        = push_data;
    @(posedge CLK); #1;
    instr_done = 1'b0; reti = 1'b0; ie_set = 1'b0; ie_clr = 1'b0;
    cyc++;
    if (hs_push) begin stk.push_back(pd); push_log.push_back(pd); end
    if (hs_pop && stk.size() > 0) void'(stk.pop_back());
    pop_data = (stk.size() > 0) ? stk[$] : 16'h0000;
    if (prev_wait && push_valid && push_data !== pd) viol++;
    if (irq_ack) begin
      ack_cnt++; ack_cyc = cyc; ack_pc = pc_value; ack_pload = pc_load; irq_req = 1'b0;
      $display("ack  vec=%h cycle=%0d", pc_value, cyc);
    end
    if (eoi) begin
      eoi_cnt++; eoi_cyc = cyc; eoi_pc = pc_value; eoi_fl = flags_out; eoi_fload = flags_load;
      $display("eoi  pc=%h flags=%h cycle=%0d", pc_value, flags_out, cyc);
    end
    if (push_valid && push_hold > 0) begin push_ready = 1'b0; push_hold--; end
    else push_ready = 1'b1;
    if (pop_valid && pop_hold > 0) begin pop_ready = 1'b0; pop_hold--; end
    else pop_ready = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({ie, in_service, push_valid, pop_valid, cpu_stall, irq_ack, eoi, pc_load, flags_load} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0",
        {ie, in_service, push_valid, pop_valid, cpu_stall, irq_ack, eoi, pc_load, flags_load});
    end
    n_checks++;
    if ({push_data, pc_value, flags_out} !== 40'h0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {push_data, pc_value, flags_out});
    end
    RST = 1'b1; m_ie = 1'b0; m_isr = 1'b0;
    step();
  endtask

  task automatic test_entry();
    ie_set = 1'b1; step();
    n_checks++;
    if (ie !== 1'b1) begin n_fail++; $display("FAIL entry_ei got %b want 1", ie); end
    irq_vec = 16'hFFF9; pc_in = 16'h0123; flags_in = 8'hA5; irq_req = 1'b1; instr_done = 1'b1;
    clr_obs();
    repeat (6) step();
    n_checks++;
    if (ack_cyc !== 3) begin n_fail++; $display("FAIL entry_ack_cycle got %0d want 3", ack_cyc); end
    n_checks++;
    if (ack_pc !== 16'hFFF9 || ack_pload !== 1'b1) begin
      n_fail++; $display("FAIL entry_vector got %h/%b want fff9/1", ack_pc, ack_pload);
    end
    n_checks++;
    if (push_log.size() != 2 || push_log[0] !== 16'h0123 || push_log[1] !== 16'h01A5) begin
      n_fail++; $display("FAIL entry_pushes got n=%0d %h %h want 0123 01a5",
        push_log.size(), push_log[0], push_log[1]);
    end
    n_checks++;
    if ({ie, in_service, cpu_stall} !== 3'b010) begin
      n_fail++; $display("FAIL entry_after got ie/isr/stall=%b want 010", {ie, in_service, cpu_stall});
    end
    m_ie = 1'b0; m_isr = 1'b1;
  endtask

  task automatic test_return();
    reti = 1'b1; instr_done = 1'b1;
    clr_obs();
    repeat (6) step();
    n_checks++;
    if (eoi_cyc !== 3) begin n_fail++; $display("FAIL return_eoi_cycle got %0d want 3", eoi_cyc); end
    n_checks++;
    if (eoi_pc !== 16'h0123 || eoi_fl !== 8'hA5 || eoi_fload !== 1'b1) begin
      n_fail++; $display("FAIL return_restore got pc=%h fl=%h ld=%b want 0123 a5 1", eoi_pc, eoi_fl, eoi_fload);
    end
    n_checks++;
    if ({ie, in_service} !== 2'b10 || stk.size() != 0) begin
      n_fail++; $display("FAIL return_after got ie/isr=%b depth=%0d want 10 0", {ie, in_service}, stk.size());
    end
    m_ie = 1'b1; m_isr = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] pc, vec, wfl;
    logic [7:0]  fl;
    int          ph;
    pc = 16'($urandom); fl = 8'($urandom); vec = 16'($urandom_range(1, 16'hFFFF));
    wfl = 16'(fl) | (16'(m_ie) << 8);
    irq_vec = vec; pc_in = pc; flags_in = fl; irq_req = 1'b1; instr_done = 1'b1;
    push_hold = 4;
    clr_obs();
    repeat (10) step();
    n_checks++;
    if (ack_cyc !== 7) begin n_fail++; $display("FAIL bp_ack_cycle got %0d want 7", ack_cyc); end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL bp_data_stable got %0d changes want 0", viol); end
    n_checks++;
    if (push_log.size() != 2 || push_log[0] !== pc || push_log[1] !== wfl || ack_pc !== vec) begin
      n_fail++; $display("FAIL bp_pushes got %h %h vec=%h want %h %h vec=%h",
        push_log[0], push_log[1], ack_pc, pc, wfl, vec);
    end
    ph = $urandom_range(1, 3); pop_hold = ph;
    reti = 1'b1; instr_done = 1'b1;
    clr_obs();
    repeat (10) step();
    n_checks++;
    if (eoi_cyc !== 3 + ph || eoi_pc !== pc || eoi_fl !== fl || ie !== 1'b1) begin
      n_fail++; $display("FAIL bp_return got cyc=%0d pc=%h fl=%h ie=%b want %0d %h %h 1",
        eoi_cyc, eoi_pc, eoi_fl, ie, 3 + ph, pc, fl);
    end
  endtask

  task automatic test_masking();
    ie_clr = 1'b1; step();
    n_checks++;
    if (ie !== 1'b0) begin n_fail++; $display("FAIL mask_di got %b want 0", ie); end
    irq_req = 1'b1; irq_vec = 16'($urandom_range(1, 16'hFFFF)); pc_in = 16'($urandom); instr_done = 1'b1;
    clr_obs();
    repeat (5) step();
    n_checks++;
    if (push_log.size() != 0 || ack_cnt != 0) begin
      n_fail++; $display("FAIL mask_ie0 got pushes=%0d acks=%0d want 0 0", push_log.size(), ack_cnt);
    end
    ie_set = 1'b1; step();
    irq_vec = 16'h0000; instr_done = 1'b1;
    clr_obs();
    repeat (5) step();
    n_checks++;
    if (push_log.size() != 0 || ack_cnt != 0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL mask_vec0 got pushes=%0d acks=%0d want 0 0", push_log.size(), ack_cnt);
    end
    ie_set = 1'b1; ie_clr = 1'b1; step();
    n_checks++;
    if (ie !== 1'b0) begin n_fail++; $display("FAIL mask_clr_wins got %b want 0", ie); end
    irq_req = 1'b0; m_ie = 1'b0;
  endtask

  task automatic test_nesting_coincidence();
    logic [15:0] v1, v2;
    v1 = 16'($urandom_range(1, 16'hFFFF)); v2 = 16'($urandom_range(1, 16'hFFFF));
    ie_set = 1'b1; step();
    irq_req = 1'b1; irq_vec = v1; pc_in = 16'($urandom); flags_in = 8'($urandom); instr_done = 1'b1;
    repeat (6) step();
    ie_set = 1'b1; step();
    n_checks++;
    if ({ie, in_service} !== 2'b11) begin
      n_fail++; $display("FAIL nest_ei_in_handler got ie/isr=%b want 11", {ie, in_service});
    end
    irq_req = 1'b1; irq_vec = v2; instr_done = 1'b1;
    clr_obs();
    repeat (5) step();
    n_checks++;
    if (push_log.size() != 0 || ack_cnt != 0) begin
      n_fail++; $display("FAIL nest_blocked got pushes=%0d acks=%0d want 0 0", push_log.size(), ack_cnt);
    end
    reti = 1'b1; instr_done = 1'b1;
    clr_obs();
    repeat (6) step();
    n_checks++;
    if (eoi_cnt != 1 || ack_cnt != 0 || push_log.size() != 0 || eoi_cyc !== 3) begin
      n_fail++; $display("FAIL coinc_reti_first got eoi=%0d@%0d acks=%0d pushes=%0d want 1@3 0 0",
        eoi_cnt, eoi_cyc, ack_cnt, push_log.size());
    end
    n_checks++;
    if ({ie, in_service} !== 2'b10) begin
      n_fail++; $display("FAIL coinc_restored got ie/isr=%b want 10", {ie, in_service});
    end
    instr_done = 1'b1;
    clr_obs();
    repeat (6) step();
    n_checks++;
    if (ack_cnt != 1 || ack_pc !== v2 || ack_cyc !== 3) begin
      n_fail++; $display("FAIL coinc_taken_later got acks=%0d vec=%h cyc=%0d want 1 %h 3", ack_cnt, ack_pc, ack_cyc, v2);
    end
    reti = 1'b1; instr_done = 1'b1;
    repeat (6) step();
    m_ie = 1'b1; m_isr = 1'b0;
  endtask

  task automatic test_reset_mid();
    ie_set = 1'b1; step();
    irq_req = 1'b1; irq_vec = 16'($urandom_range(1, 16'hFFFF)); pc_in = 16'($urandom); instr_done = 1'b1;
    clr_obs();
    repeat (2) step();
    n_checks++;
    if (push_valid !== 1'b1 || push_log.size() != 1) begin
      n_fail++; $display("FAIL rstmid_in_push_fl got valid=%b pushes=%0d want 1 1", push_valid, push_log.size());
    end
    RST = 1'b0; step();
    n_checks++;
    if ({push_valid, ie, in_service, cpu_stall, irq_ack} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_idle got %b want 0", {push_valid, ie, in_service, cpu_stall, irq_ack});
    end
    RST = 1'b1;
    repeat (3) step();
    n_checks++;
    if (ack_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_ack got %0d want 0", ack_cnt); end
    ie_set = 1'b1; ie_clr = 1'b1; step();
    n_checks++;
    if (ie !== 1'b0) begin n_fail++; $display("FAIL rstmid_clr_wins got %b want 0", ie); end
    stk.delete(); pop_data = 16'h0000; irq_req = 1'b0; m_ie = 1'b0; m_isr = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] pc, vec, wfl;
    logic [7:0]  fl;
    int          ctl, ph, qh;
    logic        take;
    for (int it = 0; it < 10; it++) begin
      ctl = $urandom_range(0, 3);
      ie_set = (ctl == 1 || ctl == 3); ie_clr = (ctl == 2 || ctl == 3);
      step();
      if (ctl == 2 || ctl == 3) m_ie = 1'b0;
      else if (ctl == 1) m_ie = 1'b1;
      n_checks++;
      if (ie !== m_ie) begin n_fail++; $display("FAIL rnd_ie it=%0d got %b want %b", it, ie, m_ie); end
      pc = 16'($urandom); fl = 8'($urandom);
      vec = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
      wfl = 16'(fl) | (16'(m_ie) << 8);
      take = m_ie && (vec != 16'h0000) && !m_isr;
      ph = $urandom_range(0, 3); push_hold = ph;
      irq_req = 1'b1; irq_vec = vec; pc_in = pc; flags_in = fl; instr_done = 1'b1;
      clr_obs();
      repeat (12) step();
      if (take) begin
        n_checks++;
        if (ack_cnt != 1 || ack_cyc !== 3 + ph || ack_pc !== vec || viol != 0) begin
          n_fail++; $display("FAIL rnd_entry it=%0d got acks=%0d cyc=%0d vec=%h want 1 %0d %h",
            it, ack_cnt, ack_cyc, ack_pc, 3 + ph, vec);
        end
        n_checks++;
        if (push_log.size() != 2 || push_log[0] !== pc || push_log[1] !== wfl) begin
          n_fail++; $display("FAIL rnd_pushes it=%0d got %h %h want %h %h", it, push_log[0], push_log[1], pc, wfl);
        end
        qh = $urandom_range(0, 3); pop_hold = qh;
        reti = 1'b1; instr_done = 1'b1;
        clr_obs();
        repeat (10) step();
        n_checks++;
        if (eoi_cyc !== 3 + qh || eoi_pc !== pc || eoi_fl !== fl || ie !== wfl[8] || in_service !== 1'b0) begin
          n_fail++; $display("FAIL rnd_return it=%0d got cyc=%0d pc=%h fl=%h ie=%b want %0d %h %h %b",
            it, eoi_cyc, eoi_pc, eoi_fl, ie, 3 + qh, pc, fl, wfl[8]);
        end
        m_ie = wfl[8];
      end else begin
        n_checks++;
        if (ack_cnt != 0 || push_log.size() != 0) begin
          n_fail++; $display("FAIL rnd_masked it=%0d got acks=%0d pushes=%0d want 0 0", it, ack_cnt, push_log.size());
        end
      end
      irq_req = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    RST = 1'b0; irq_req = 1'b0; irq_vec = '0; instr_done = 1'b0; reti = 1'b0;
    ie_set = 1'b0; ie_clr = 1'b0; pc_in = '0; flags_in = '0; pop_data = '0;
    push_ready = 1'b1; pop_ready = 1'b1; push_hold = 0; pop_hold = 0;
    m_ie = 1'b0; m_isr = 1'b0;
    clr_obs();
    test_reset();
    test_entry();
    test_return();
    test_backpressure();
    test_masking();
    test_nesting_coincidence();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
